sprite_anim_src: RTL and testbench

Parametrised, animated sprite pixel source for the VGA pixel pipeline. It supersedes the fixed 32x64, four-frame doodle source. Per pixel, it maps the scan position (x, y) relative to the sprite origin (x0, y0) into a frame-indexed sprite RAM and resolves the stored palette code through a run-time writable palette. It emits a chroma-keyed colour two clocks later to the layer mux. New behaviour: configurable size and frame count, horizontal flip, programmable animation rate, and four animation modes including one-shot with a done flag and ping-pong.

---
 rtl/sprite_anim_src.sv | 162 ++++++++++++++++
 tb/tb_sprite_anim_src.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_anim_src.sv
// Animated sprite pixel source: scan position -> frame-indexed sprite RAM -> palette -> chroma-keyed colour.
// Two-clock pixel path; the frame sequencer advances on frame ticks at a programmable rate.
module sprite_anim_src #(
  parameter int             CD        = 12,
  parameter int             HB        = 5,
  parameter int             VB        = 6,
  parameter int             FB        = 2,
  parameter int             PW        = 2,
  parameter logic [CD-1:0]  KEY_COLOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [10:0]           x,
  input  logic [10:0]           y,
  input  logic [10:0]           x0,
  input  logic [10:0]           y0,
  input  logic [1:0]            mode,
  input  logic [FB-1:0]         frame_sel,
  input  logic [3:0]            rate,
  input  logic                  hflip,
  input  logic                  start,
  input  logic                  we,
  input  logic [FB+VB+HB-1:0]   addr_w,
  input  logic [PW-1:0]         pixel_in,
  input  logic                  plt_we,
  input  logic [PW-1:0]         plt_addr,
  input  logic [CD-1:0]         plt_data,
  output logic [CD-1:0]         sprite_rgb,
  output logic [FB-1:0]         cur_frame,
  output logic                  anim_done
);

  localparam int AW    = FB + VB + HB;
  localparam int DEPTH = 1 << AW;
  localparam int NPAL  = 1 << PW;

  localparam logic [1:0]    MODE_MANUAL  = 2'b00;
  localparam logic [1:0]    MODE_LOOP    = 2'b01;
  localparam logic [1:0]    MODE_ONESHOT = 2'b10;
  localparam logic [1:0]    MODE_PING    = 2'b11;
  localparam logic [FB-1:0] FRAME_MAX    = '1;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

  logic [10:0]   x_q;
  logic [3:0]    tick_cnt_q, tick_cnt_d;
  logic [FB-1:0] frame_q, frame_d;
  logic          done_q, done_d;
  dir_e          dir_q, dir_d;
  logic          frame_tick, step, going_up;
  logic [FB-1:0] pp_nxt;

  logic signed [11:0] xr, yr;
  logic               in_region;
  logic [HB-1:0]      col;
  logic [AW-1:0]      raddr;

  logic [PW-1:0] mem [DEPTH];
  logic [PW-1:0] rd_code_q;
  logic          inreg_q;
  logic [CD-1:0] plt_q [NPAL];
  logic [CD-1:0] rgb_q, rgb_d;

  // Manual mode bypasses the frame register; reset still forces frame 0.
  assign cur_frame  = (mode == MODE_MANUAL && !reset) ? frame_sel : frame_q;
  assign anim_done  = done_q;
  assign sprite_rgb = rgb_q;

  assign xr        = $signed({1'b0, x}) - $signed({1'b0, x0});
  assign yr        = $signed({1'b0, y}) - $signed({1'b0, y0});
  assign in_region = (xr[11:HB] == '0) && (yr[11:VB] == '0);
  assign col       = hflip ? ~xr[HB-1:0] : xr[HB-1:0];
  assign raddr     = {cur_frame, yr[VB-1:0], col};

  // Stage 1: sprite RAM, read-before-write on a same-address collision
  always_ff @(posedge clk) begin
    if (we) mem[addr_w] <= pixel_in;
    rd_code_q <= mem[raddr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPAL; i++) plt_q[i] <= (i == 0) ? KEY_COLOR : '1;
    end else if (plt_we) begin
      plt_q[plt_addr] <= plt_data;
    end
  end

  // Stage 2: palette lookup and keying
  always_comb begin
    rgb_d = plt_q[rd_code_q];
    if (!inreg_q || rd_code_q == '0) rgb_d = KEY_COLOR;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inreg_q <= 1'b0;
      rgb_q   <= KEY_COLOR;
    end else begin
      inreg_q <= in_region;
      rgb_q   <= rgb_d;
    end
  end

  always_comb begin
    frame_tick = (x_q == '0) && (x == 11'd1) && (y == '0);
    step       = frame_tick && (tick_cnt_q == rate);
    tick_cnt_d = tick_cnt_q;
    frame_d    = frame_q;
    done_d     = done_q;
    dir_d      = dir_q;
    going_up   = (dir_q == DIR_UP) ? (frame_q != FRAME_MAX) : (frame_q == '0);
    pp_nxt     = going_up ? frame_q + 1'b1 : frame_q - 1'b1;

    if (frame_tick) tick_cnt_d = step ? 4'd0 : tick_cnt_q + 4'd1;

    case (mode)
      MODE_MANUAL: frame_d = frame_sel;
      MODE_LOOP: if (step) frame_d = frame_q + 1'b1;
      MODE_ONESHOT: begin
        if (step) begin
          if (frame_q != FRAME_MAX) frame_d = frame_q + 1'b1;
          if (frame_q == FRAME_MAX || frame_q + 1'b1 == FRAME_MAX) done_d = 1'b1;
        end
      end
      MODE_PING: begin
        // Turn around at either end; a stale direction at an end is also corrected here.
        if (step) begin
          frame_d = pp_nxt;
          if (pp_nxt == FRAME_MAX)  dir_d = DIR_DOWN;
          else if (pp_nxt == '0)    dir_d = DIR_UP;
          else                      dir_d = going_up ? DIR_UP : DIR_DOWN;
        end
      end
      default: frame_d = frame_q;
    endcase

    if (start) begin
      tick_cnt_d = 4'd0;
      frame_d    = '0;
      done_d     = 1'b0;
      dir_d      = DIR_UP;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q        <= '0;
      tick_cnt_q <= '0;
      frame_q    <= '0;
      done_q     <= 1'b0;
      dir_q      <= DIR_UP;
    end else begin
      x_q        <= x;
      tick_cnt_q <= tick_cnt_d;
      frame_q    <= frame_d;
      done_q     <= done_d;
      dir_q      <= dir_d;
    end
  end

endmodule

// File: tb/tb_sprite_anim_src.sv
// Bench for sprite_anim_src: directed scenarios plus randomized traffic against a behavioural model.
module tb_sprite_anim_src;

  localparam int CD = 12, HB = 5, VB = 6, FB = 2, PW = 2;
  localparam int H = 1 << HB, V = 1 << VB, F = 1 << FB;
  localparam int AW = FB + VB + HB;
  localparam logic [CD-1:0] KEY = 12'h000;

  logic           clk, rst;
  logic [10:0]    x, y, x0, y0;
  logic [1:0]     mode;
  logic [FB-1:0]  frame_sel;
  logic [3:0]     rate;
  logic           hflip, start, we, plt_we;
  logic [AW-1:0]  addr_w;
  logic [PW-1:0]  pixel_in, plt_addr;
  logic [CD-1:0]  plt_data;
  logic [CD-1:0]  sprite_rgb;
  logic [FB-1:0]  cur_frame;
  logic           anim_done;

  sprite_anim_src #(.CD(CD), .HB(HB), .VB(VB), .FB(FB), .PW(PW), .KEY_COLOR(KEY)) dut (
    .clk(clk), .reset(rst), .x(x), .y(y), .x0(x0), .y0(y0), .mode(mode),
    .frame_sel(frame_sel), .rate(rate), .hflip(hflip), .start(start), .we(we),
    .addr_w(addr_w), .pixel_in(pixel_in), .plt_we(plt_we), .plt_addr(plt_addr),
    .plt_data(plt_data), .sprite_rgb(sprite_rgb), .cur_frame(cur_frame), .anim_done(anim_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  bit chk_en = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [PW-1:0] mmem [1 << AW];
  logic [CD-1:0] mpal [1 << PW];
  int m_px, m_n, m_pmode, m_prate, m_frm, m_s1_code;
  bit m_done, m_s1_in;
  logic [CD-1:0] m_rgb;

  // Frame shown after a given number of steps since the last start.
  function automatic int frame_after(input int md, input int st);
    int p;
    case (md)
      1: return st % F;
      2: return (st >= F - 1) ? F - 1 : st;
      3: begin
        p = st % (2 * (F - 1));
        return (p < F) ? p : 2 * (F - 1) - p;
      end
      default: return 0;
    endcase
  endfunction

  function automatic int exp_cur();
    return (mode == 2'b00) ? int'(frame_sel) : m_frm;
  endfunction

  function automatic bit in_reg_now();
    int xr = int'(x) - int'(x0);
    int yr = int'(y) - int'(y0);
    return (xr >= 0 && xr < H && yr >= 0 && yr < V);
  endfunction

  function automatic int rd_idx();
    int xr = int'(x) - int'(x0);
    int yr = int'(y) - int'(y0);
    int c = hflip ? (H - 1) - (xr & (H - 1)) : (xr & (H - 1));
    return exp_cur() * H * V + (yr & (V - 1)) * H + c;
  endfunction

  function automatic int next_n();
    if (start) return 0;
    if (m_px == 0 && x == 11'd1 && y == 11'd0) return m_n + 1;
    return m_n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_px <= 0; m_n <= 0; m_pmode <= int'(mode); m_prate <= int'(rate);
      m_frm <= 0; m_done <= 1'b0; m_s1_in <= 1'b0; m_s1_code <= 0; m_rgb <= KEY;
      for (int i = 0; i < (1 << PW); i++) mpal[i] <= (i == 0) ? KEY : 12'hfff;
    end else begin
      m_rgb     <= (!m_s1_in || m_s1_code == 0) ? KEY : mpal[m_s1_code];
      m_s1_in   <= in_reg_now();
      m_s1_code <= int'(mmem[rd_idx()]);
      m_n       <= next_n();
      m_pmode   <= start ? int'(mode) : m_pmode;
      m_prate   <= start ? int'(rate) : m_prate;
      m_frm     <= start ? 0 : (m_pmode == 0 ? int'(frame_sel)
                                  : frame_after(m_pmode, next_n() / (m_prate + 1)));
      m_done    <= start ? 1'b0 : (m_pmode == 2 && next_n() / (m_prate + 1) >= F - 1);
      m_px      <= int'(x);
      if (we) mmem[addr_w] <= pixel_in;
      if (plt_we) mpal[plt_addr] <= plt_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_rgb", int'(sprite_rgb), int'(m_rgb));
      check("model_cur_frame", int'(cur_frame), exp_cur());
      check("model_anim_done", int'(anim_done), int'(m_done));
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [CD-1:0] res [34];

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_px(input int f, input int r, input int c, input int code);
    addr_w = AW'(f * H * V + r * H + c); pixel_in = PW'(code); we = 1'b1;
    cyc();
    we = 1'b0;
  endtask

  task automatic wr_plt(input int idx, input int colr);
    plt_addr = PW'(idx); plt_data = CD'(colr); plt_we = 1'b1;
    cyc();
    plt_we = 1'b0;
  endtask

  task automatic pulse_start(input int md, input int rt);
    mode = 2'(md); rate = 4'(rt); start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic tick(input bit with_start);
    x = 11'd0; y = 11'd0;
    cyc();
    x = 11'd1; start = with_start;
    cyc();
    start = 1'b0; x = 11'd7; y = 11'd500;
    cyc();
  endtask

  task automatic scan(input bit hf);
    hflip = hf; y = 11'd50;
    for (int j = 0; j <= 34; j++) begin
      if (j < 34) x = 11'(99 + j);
      else begin x = 11'd7; y = 11'd500; end
      cyc();
      if (j >= 1) res[j - 1] = sprite_rgb;
    end
  endtask

  int exp_loop[12] = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int exp_pp[8]    = '{1, 2, 3, 2, 1, 0, 1, 2};

  initial begin
    rst = 1'b0; x = 11'd7; y = 11'd500; x0 = 11'd100; y0 = 11'd50;
    mode = 2'b00; frame_sel = 2'd3; rate = 4'd0; hflip = 1'b0; start = 1'b0;
    we = 1'b0; addr_w = '0; pixel_in = '0; plt_we = 1'b0; plt_addr = '0; plt_data = '0;
    #1 rst = 1'b1;
    cyc(); cyc();
    check("reset_rgb", int'(sprite_rgb), int'(KEY));
    check("reset_cur_frame", int'(cur_frame), 0);
    check("reset_anim_done", int'(anim_done), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    frame_sel = 2'd0;
    pulse_start(0, 0);

    for (int a = 0; a < (1 << AW); a++) wr_px(a / (H * V), (a / H) % V, a % H, 0);

    wr_px(0, 0, 0, 2);
    wr_px(0, 0, 31, 3);
    scan(1'b0);
    check("scan_x99_key", int'(res[0]), 12'h000);
    check("scan_x100", int'(res[1]), 12'hfff);
    check("scan_x110_code0", int'(res[11]), 12'h000);
    check("scan_x131", int'(res[32]), 12'hfff);
    check("scan_x132_key", int'(res[33]), 12'h000);

    wr_px(0, 0, 1, 1);
    wr_plt(1, 12'h0f0);
    scan(1'b1);
    check("hflip_x100_code3", int'(res[1]), 12'hfff);
    check("hflip_x130_code1", int'(res[31]), 12'h0f0);
    check("hflip_x131_code2", int'(res[32]), 12'hfff);
    wr_plt(2, 12'hf00);
    wr_plt(0, 12'habc);
    scan(1'b1);
    check("hflip_pal_x131", int'(res[32]), 12'hf00);
    check("hflip_pal_x100", int'(res[1]), 12'hfff);
    check("pal0_still_key", int'(res[10]), 12'h000);
    scan(1'b0);
    check("noflip_pal_x100", int'(res[1]), 12'hf00);

    pulse_start(1, 2);
    for (int t = 0; t < 12; t++) begin
      tick(1'b0);
      check($sformatf("loop_tick%0d", t + 1), int'(cur_frame), exp_loop[t]);
    end

    pulse_start(2, 0);
    for (int t = 0; t < 3; t++) tick(1'b0);
    check("oneshot_frame", int'(cur_frame), 3);
    check("oneshot_done", int'(anim_done), 1);
    for (int t = 0; t < 5; t++) begin
      tick(1'b0);
      check("oneshot_hold_frame", int'(cur_frame), 3);
      check("oneshot_hold_done", int'(anim_done), 1);
    end
    tick(1'b1);
    check("oneshot_restart_frame", int'(cur_frame), 0);
    check("oneshot_restart_done", int'(anim_done), 0);

    pulse_start(3, 0);
    for (int t = 0; t < 8; t++) begin
      tick(1'b0);
      check($sformatf("pingpong_tick%0d", t + 1), int'(cur_frame), exp_pp[t]);
    end

    wr_px(2, 0, 0, 1);
    wr_plt(1, 12'h0a5);
    frame_sel = 2'd2;
    pulse_start(0, 0);
    hflip = 1'b0; x = 11'd100; y = 11'd50;
    cyc(); cyc();
    check("manual_frame2", int'(sprite_rgb), 12'h0a5);
    #1 rst = 1'b1;
    #1;
    check("midscan_reset_rgb", int'(sprite_rgb), int'(KEY));
    check("midscan_reset_frame", int'(cur_frame), 0);
    cyc();
    rst = 1'b0;
    cyc();
    check("post_reset_1clk", int'(sprite_rgb), int'(KEY));
    cyc();
    check("post_reset_2clk", int'(sprite_rgb), 12'hfff);
    pulse_start(0, 0);

    for (int c = 0; c < 4000; c++) begin
      int r;
      if (c % 400 == 0) begin
        mode = 2'($urandom_range(0, 3)); rate = 4'($urandom_range(0, 2)); start = 1'b1;
      end else begin
        start = ($urandom_range(0, 499) == 0);
      end
      r = $urandom_range(0, 7);
      if (r == 0) begin x = 11'd0; y = 11'd0; end
      else if (r == 1) begin x = 11'd1; y = 11'd0; end
      else begin x = 11'($urandom_range(95, 134)); y = 11'($urandom_range(45, 118)); end
      if ($urandom_range(0, 9) == 0) begin
        x0 = 11'($urandom); y0 = 11'($urandom);
      end else if ($urandom_range(0, 9) == 0) begin
        x0 = 11'd100; y0 = 11'd50;
      end
      hflip = 1'($urandom);
      frame_sel = 2'($urandom);
      we = ($urandom_range(0, 3) == 0);
      addr_w = AW'($urandom); pixel_in = PW'($urandom);
      plt_we = ($urandom_range(0, 31) == 0);
      plt_addr = PW'($urandom); plt_data = CD'($urandom);
      cyc();
    end
    start = 1'b0; we = 1'b0; plt_we = 1'b0;
    cyc(); cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
